rr_mux: RTL and testbench

Four-to-one collector. It merges four 8-bit source channels A/B/C/D onto a single output stream, tagged with the 2-bit source index, and is the sink-side counterpart of the demux fan-out. Each channel has a one-entry input buffer. A round-robin arbiter picks among full buffers and loads a registered output stage. The output stage uses a valid/ready handshake so downstream can stall.

---
 rtl/rr_mux_if.sv | 21 ++
 rtl/rr_mux.sv | 110 +++++++++++
 tb/tb_rr_mux.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_if.sv
// Handshake bundle for the 4:1 round-robin collector: four source channels in,
// one tagged valid/ready output stream.
interface rr_mux_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] A, B, C, D;
    logic             A_valid, B_valid, C_valid, D_valid;
    logic             A_ready, B_ready, C_ready, D_ready;
    logic             out_ready;
    logic [WIDTH-1:0] data;
    logic [1:0]       Sel;
    logic             Enable;

    modport master (
        output A, B, C, D, A_valid, B_valid, C_valid, D_valid, out_ready,
        input  A_ready, B_ready, C_ready, D_ready, data, Sel, Enable
    );

    modport slave (
        input  A, B, C, D, A_valid, B_valid, C_valid, D_valid, out_ready,
        output A_ready, B_ready, C_ready, D_ready, data, Sel, Enable
    );
endinterface

// File: rtl/rr_mux.sv
// Four one-entry channel buffers merged by a round-robin arbiter into a
// registered valid/ready output stage tagged with the source index.
module rr_mux_lane #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [WIDTH-1:0] buf_data,
    output logic             buf_full
);
    // Ready depends only on state and reset, so no input-to-ready path exists.
    assign in_ready = ~reset & ~buf_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (clr) begin
            buf_full <= 1'b0;
        end else if (in_valid && in_ready) begin
            buf_full <= 1'b1;
            buf_data <= in_data;
        end
    end
endmodule

module rr_mux #(parameter int WIDTH = 8) (
    input  logic     clk,
    input  logic     reset,
    rr_mux_if.slave  bus
);
    localparam int NUM_LANES = 4;

    typedef enum logic {EMPTY, FULL} state_t;

    logic [NUM_LANES-1:0][WIDTH-1:0] in_data, buf_data;
    logic [NUM_LANES-1:0]            in_valid, in_ready, buf_full, clr;
    logic [1:0]                      ptr, gnt;
    logic                            gnt_vld, load_ok, transfer;
    logic [WIDTH-1:0]                data_q;
    logic [1:0]                      sel_q;
    state_t                          state, state_nxt;

    assign in_data  = {bus.D, bus.C, bus.B, bus.A};
    assign in_valid = {bus.D_valid, bus.C_valid, bus.B_valid, bus.A_valid};
    assign bus.A_ready = in_ready[0];
    assign bus.B_ready = in_ready[1];
    assign bus.C_ready = in_ready[2];
    assign bus.D_ready = in_ready[3];

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            rr_mux_lane #(.WIDTH(WIDTH)) u_lane (
                .clk      (clk),
                .reset    (reset),
                .in_data  (in_data[i]),
                .in_valid (in_valid[i]),
                .in_ready (in_ready[i]),
                .clr      (clr[i]),
                .buf_data (buf_data[i]),
                .buf_full (buf_full[i])
            );
        end
    endgenerate

    // Walk offsets 4..1 so the smallest offset from ptr is the last to win.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            if (buf_full[ptr + 2'(k)]) begin
                gnt_vld = 1'b1;
                gnt     = ptr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_ok   = (state == EMPTY) | bus.out_ready;
        transfer  = load_ok & gnt_vld;
        clr       = '0;
        if (load_ok) state_nxt = gnt_vld ? FULL : EMPTY;
        if (transfer) clr = NUM_LANES'(1) << gnt;
    end

    // Payload and tag hold their last values when the stage drains empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            sel_q  <= '0;
            ptr    <= 2'd3;
        end else if (transfer) begin
            data_q <= buf_data[gnt];
            sel_q  <= gnt;
            ptr    <= gnt;
        end
    end

    assign bus.data   = data_q;
    assign bus.Sel    = sel_q;
    assign bus.Enable = (state == FULL);
endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: reset, latency, arbitration order, stall,
// sustained rotation with a per-channel scoreboard, and mid-run reset.
module tb_rr_mux;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rr_mux_if #(.WIDTH(8)) bus();
    rr_mux #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [7:0] d, input logic v);
        case (i)
            0: begin bus.A = d; bus.A_valid = v; end
            1: begin bus.B = d; bus.B_valid = v; end
            2: begin bus.C = d; bus.C_valid = v; end
            default: begin bus.D = d; bus.D_valid = v; end
        endcase
    endtask

    function automatic logic [3:0] readys();
        return {bus.D_ready, bus.C_ready, bus.B_ready, bus.A_ready};
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 4; i++) drive(i, 8'h00, 1'b0);
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) drive(i, 8'h5A, 1'b1);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", bus.Enable); end
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data); end
        checks++; if (bus.Sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.Sel); end
        checks++; if (readys() !== 4'b0000) begin errors++; $display("FAIL reset_ready_low: got %b want 0000", readys()); end
        for (int i = 0; i < 4; i++) drive(i, 8'h00, 1'b0);
        reset = 1'b0;
        #1;
        checks++; if (readys() !== 4'b1111) begin errors++; $display("FAIL reset_ready_rel: got %b want 1111", readys()); end
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 8'h11, 1'b1);
        tick();
        drive(0, 8'h00, 1'b0);
        checks++; if (bus.A_ready !== 1'b0) begin errors++; $display("FAIL single_a_busy: got %b want 0", bus.A_ready); end
        checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus.Enable); end
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd0, 8'h11})
            begin errors++; $display("FAIL single_beat: got en=%b sel=%0d data=%h want 1/0/11", bus.Enable, bus.Sel, bus.data); end
        tick();
        checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", bus.Enable); end
        checks++; if (bus.A_ready !== 1'b1) begin errors++; $display("FAIL single_a_free: got %b want 1", bus.A_ready); end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 8'(i + 1), 1'b1);
        tick();
        for (int i = 0; i < 4; i++) drive(i, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'(k), 8'(k + 1)})
                begin errors++; $display("FAIL all4_beat%0d: got en=%b sel=%0d data=%h want 1/%0d/%h", k, bus.Enable, bus.Sel, bus.data, k, k + 1); end
        end
        tick();
        checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL all4_drop: got %b want 0", bus.Enable); end
    endtask

    task automatic test_priority();
        do_reset();
        drive(3, 8'h44, 1'b1);
        drive(1, 8'h22, 1'b1);
        tick();
        drive(3, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd1, 8'h22})
            begin errors++; $display("FAIL prio_b_first: got en=%b sel=%0d data=%h want 1/1/22", bus.Enable, bus.Sel, bus.data); end
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd3, 8'h44})
            begin errors++; $display("FAIL prio_d_second: got en=%b sel=%0d data=%h want 1/3/44", bus.Enable, bus.Sel, bus.data); end
        drive(0, 8'h55, 1'b1);
        drive(2, 8'h66, 1'b1);
        tick();
        drive(0, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd0, 8'h55})
            begin errors++; $display("FAIL prio_a_after_d: got en=%b sel=%0d data=%h want 1/0/55", bus.Enable, bus.Sel, bus.data); end
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd2, 8'h66})
            begin errors++; $display("FAIL prio_c_last: got en=%b sel=%0d data=%h want 1/2/66", bus.Enable, bus.Sel, bus.data); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.out_ready = 1'b0;
        drive(2, 8'hAA, 1'b1);
        tick();
        drive(2, 8'h00, 1'b0);
        tick();
        drive(0, 8'h01, 1'b1);
        drive(1, 8'h02, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin drive(0, 8'h00, 1'b0); drive(1, 8'h00, 1'b0); end
            checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd2, 8'hAA})
                begin errors++; $display("FAIL stall_hold%0d: got en=%b sel=%0d data=%h want 1/2/aa", i, bus.Enable, bus.Sel, bus.data); end
        end
        checks++; if (readys() !== 4'b1100) begin errors++; $display("FAIL stall_ready: got %b want 1100", readys()); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd0, 8'h01})
            begin errors++; $display("FAIL stall_release_a: got en=%b sel=%0d data=%h want 1/0/01", bus.Enable, bus.Sel, bus.data); end
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd1, 8'h02})
            begin errors++; $display("FAIL stall_release_b: got en=%b sel=%0d data=%h want 1/1/02", bus.Enable, bus.Sel, bus.data); end
        tick();
        checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", bus.Enable); end
    endtask

    task automatic test_back_to_back();
        int sent [4];
        int rcv  [4];
        logic [3:0] acc;
        int beats = 0;
        int cyc = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            rcv[i]  = 0;
            drive(i, {2'(i), 6'd0}, 1'b1);
        end
        while (beats < 40 && cyc < 80) begin
            acc = readys();
            tick();
            cyc++;
            for (int i = 0; i < 4; i++)
                if (acc[i]) begin sent[i]++; drive(i, {2'(i), 6'(sent[i])}, 1'b1); end
            if (bus.Enable === 1'b1) begin
                checks++; if (bus.Sel !== 2'(beats))
                    begin errors++; $display("FAIL b2b_order%0d: got sel=%0d want %0d", beats, bus.Sel, beats % 4); end
                checks++; if (bus.data !== {bus.Sel, 6'(rcv[bus.Sel])})
                    begin errors++; $display("FAIL b2b_data%0d: got %h want %h", beats, bus.data, {bus.Sel, 6'(rcv[bus.Sel])}); end
                rcv[bus.Sel]++;
                beats++;
            end else if (beats > 0) begin
                checks++; errors++;
                $display("FAIL b2b_bubble: got Enable=0 after %0d beats want 1", beats);
            end
        end
        checks++; if (beats != 40) begin errors++; $display("FAIL b2b_timeout: got %0d beats want 40", beats); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rcv[i] != 10) begin errors++; $display("FAIL b2b_count%0d: got %0d want 10", i, rcv[i]); end
        end
        for (int i = 0; i < 4; i++) drive(i, 8'h00, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 8'(8'h70 + i), 1'b1);
        tick();
        for (int i = 0; i < 4; i++) drive(i, 8'h00, 1'b0);
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd0, 8'h70})
            begin errors++; $display("FAIL mid_setup: got en=%b sel=%0d data=%h want 1/0/70", bus.Enable, bus.Sel, bus.data); end
        reset = 1'b1;
        tick();
        checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL mid_enable: got %b want 0", bus.Enable); end
        reset = 1'b0;
        #1;
        checks++; if (readys() !== 4'b1111) begin errors++; $display("FAIL mid_bufs_empty: got %b want 1111", readys()); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b want 0", bus.Enable); end
        drive(2, 8'hCC, 1'b1);
        tick();
        drive(2, 8'h00, 1'b0);
        tick();
        checks++; if ({bus.Enable, bus.Sel, bus.data} !== {1'b1, 2'd2, 8'hCC})
            begin errors++; $display("FAIL mid_first_c: got en=%b sel=%0d data=%h want 1/2/cc", bus.Enable, bus.Sel, bus.data); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) drive(i, 8'h00, 1'b0);
        bus.out_ready = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_priority();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
